tiny_project_mux: RTL and testbench

TINY_PROJECT_MUX -- requirements
Module: tiny_project_mux

---
 rtl/tiny_project_mux.sv | 202 ++++++++++++++++++++
 tb/tb_tiny_project_mux.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_project_mux.sv
// ---------------------------------------------------------------------------
// tiny_project_mux
//
// Selects one of NUM_PROJ attached projects and routes its pad bundle
// (uo_out / uio_out / uio_oe) to the shared pads. A switch isolates the pads
// for one cycle, then holds the newly selected project in reset for
// RST_CYCLES enabled cycles before handing the pads over to it.
//
// Parameters
//   NUM_PROJ    number of attached projects (2..16)
//   RST_CYCLES  cycles a newly selected project is held in reset (1..255)
//   DEFAULT_SEL project selected after reset (< NUM_PROJ)
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   ena                global enable; low isolates and resets every project
//   sel_req/sel_valid  requested project index and its strobe
//   sel_ready          request is accepted when high together with sel_valid
//   sel_err            one-cycle pulse after an out-of-range request
//   proj_uo_out, proj_uio_out, proj_uio_oe
//                      per-project pad buses, project i at [8i+7:8i]
//   uo_out, uio_out, uio_oe
//                      muxed pad bundle
//   proj_rst_n         registered per-project active-low reset
//   proj_ena           one-hot enable of active_sel, gated by ena
//   active_sel         registered current project index
//   switching          high whenever a switch or reset hold is in progress
//   switch_cnt         saturating count of completed isolations
//                      (only with TINY_PROJECT_MUX_SWITCH_CNT_EN defined)
//
// Optional feature macro: TINY_PROJECT_MUX_SWITCH_CNT_EN
// ---------------------------------------------------------------------------
module tiny_project_mux #(
  parameter int NUM_PROJ    = 4,
  parameter int RST_CYCLES  = 8,
  parameter int DEFAULT_SEL = 0,
  localparam int SEL_W      = ($clog2(NUM_PROJ) < 1) ? 1 : $clog2(NUM_PROJ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [SEL_W-1:0]      sel_req,
  input  logic                  sel_valid,
  output logic                  sel_ready,
  output logic                  sel_err,
  input  logic [8*NUM_PROJ-1:0] proj_uo_out,
  input  logic [8*NUM_PROJ-1:0] proj_uio_out,
  input  logic [8*NUM_PROJ-1:0] proj_uio_oe,
  output logic [7:0]            uo_out,
  output logic [7:0]            uio_out,
  output logic [7:0]            uio_oe,
  output logic [NUM_PROJ-1:0]   proj_rst_n,
  output logic [NUM_PROJ-1:0]   proj_ena,
  output logic [SEL_W-1:0]      active_sel,
  output logic                  switching
`ifdef TINY_PROJECT_MUX_SWITCH_CNT_EN
  ,
  output logic [7:0]            switch_cnt
`endif
);

  localparam logic [1:0] ST_ACTIVE  = 2'd0;
  localparam logic [1:0] ST_ISOLATE = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  localparam logic [7:0]       CNT_RELOAD  = 8'(RST_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_DEFAULT = SEL_W'(DEFAULT_SEL);
  // One extra bit so NUM_PROJ itself is representable when it is a power of two.
  localparam logic [SEL_W:0]   NUM_PROJ_X  = (SEL_W + 1)'(NUM_PROJ);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [SEL_W-1:0]    pending;
  logic [SEL_W-1:0]    pending_nxt;
  logic [SEL_W-1:0]    active_sel_nxt;
  logic [7:0]          counter;
  logic [7:0]          counter_nxt;
  logic                sel_err_nxt;
  logic [NUM_PROJ-1:0] proj_rst_n_nxt;
  logic                req_accept;
  logic                req_oob;

  assign sel_ready  = (state == ST_ACTIVE) & ena;
  assign switching  = (state != ST_ACTIVE);
  assign req_accept = sel_valid & sel_ready;
  assign req_oob    = ({1'b0, sel_req} >= NUM_PROJ_X);

  // Next-state logic. Dropping ena overrides everything: the FSM parks in
  // HOLD with a fresh reset count. active_sel takes the pending index there
  // so a switch caught in ISOLATE still lands on its target once ena
  // returns (outside ISOLATE pending already equals active_sel).
  always_comb begin
    state_nxt      = state;
    pending_nxt    = pending;
    active_sel_nxt = active_sel;
    counter_nxt    = counter;
    sel_err_nxt    = 1'b0;
    if (!ena) begin
      state_nxt      = ST_HOLD;
      active_sel_nxt = pending;
      counter_nxt    = CNT_RELOAD;
    end else begin
      case (state)
        ST_ACTIVE: begin
          if (req_accept) begin
            if (req_oob) begin
              sel_err_nxt = 1'b1;
            end else if (sel_req != active_sel) begin
              pending_nxt = sel_req;
              state_nxt   = ST_ISOLATE;
            end
          end
        end
        ST_ISOLATE: begin
          state_nxt      = ST_HOLD;
          active_sel_nxt = pending;
          counter_nxt    = CNT_RELOAD;
        end
        ST_HOLD: begin
          if (counter == 8'd0) begin
            state_nxt = ST_ACTIVE;
          end else begin
            counter_nxt = counter - 8'd1;
          end
        end
        default: begin
          state_nxt   = ST_HOLD;
          counter_nxt = CNT_RELOAD;
        end
      endcase
    end
  end

  // A project comes out of reset on the same edge the FSM becomes ACTIVE,
  // so the reset release and the pad handover line up cycle for cycle.
  always_comb begin
    proj_rst_n_nxt = '0;
    for (int i = 0; i < NUM_PROJ; i++) begin
      proj_rst_n_nxt[i] = ena && (state_nxt == ST_ACTIVE) &&
                          (active_sel_nxt == SEL_W'(i));
    end
  end

  // Control registers. Reset discards any pending switch and restarts the
  // default project's reset hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_HOLD;
      active_sel <= SEL_DEFAULT;
      pending    <= SEL_DEFAULT;
      counter    <= CNT_RELOAD;
      proj_rst_n <= '0;
      sel_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      active_sel <= active_sel_nxt;
      pending    <= pending_nxt;
      counter    <= counter_nxt;
      proj_rst_n <= proj_rst_n_nxt;
      sel_err    <= sel_err_nxt;
    end
  end

  // Enables follow active_sel even mid-switch; the project's reset keeps it
  // quiet until the hold completes.
  always_comb begin
    proj_ena = '0;
    for (int i = 0; i < NUM_PROJ; i++) begin
      proj_ena[i] = ena && (active_sel == SEL_W'(i));
    end
  end

  // Pad mux. Anything other than an enabled ACTIVE state drives zeros,
  // which also clears uio_oe and turns the bidirectional pads into inputs.
  always_comb begin
    uo_out  = 8'h00;
    uio_out = 8'h00;
    uio_oe  = 8'h00;
    if (ena && (state == ST_ACTIVE)) begin
      for (int i = 0; i < NUM_PROJ; i++) begin
        if (active_sel == SEL_W'(i)) begin
          uo_out  = proj_uo_out[8*i +: 8];
          uio_out = proj_uio_out[8*i +: 8];
          uio_oe  = proj_uio_oe[8*i +: 8];
        end
      end
    end
  end

`ifdef TINY_PROJECT_MUX_SWITCH_CNT_EN
  // Counts every exit from ISOLATE (that exit always goes to HOLD, even
  // when ena drops in the same cycle) and sticks at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      switch_cnt <= 8'd0;
    end else if ((state == ST_ISOLATE) && (switch_cnt != 8'hFF)) begin
      switch_cnt <= switch_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tiny_project_mux.sv
// ---------------------------------------------------------------------------
// tb_tiny_project_mux
//
// Self-checking bench for tiny_project_mux. The main instance uses
// NUM_PROJ=4, RST_CYCLES=8 and is tracked by a cycles-remaining model; a
// second instance with NUM_PROJ=5, RST_CYCLES=3 exercises out-of-range
// requests, which a 2-bit request port cannot express.
// Define TINY_PROJECT_MUX_SWITCH_CNT_EN to include the switch counter checks.
// ---------------------------------------------------------------------------
module tb_tiny_project_mux;

  localparam int NUM_PROJ   = 4;
  localparam int RST_CYCLES = 8;
  localparam int SEL_W      = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  ena;
  logic [SEL_W-1:0]      sel_req;
  logic                  sel_valid;
  logic                  sel_ready;
  logic                  sel_err;
  logic [8*NUM_PROJ-1:0] proj_uo_out;
  logic [8*NUM_PROJ-1:0] proj_uio_out;
  logic [8*NUM_PROJ-1:0] proj_uio_oe;
  logic [7:0]            uo_out;
  logic [7:0]            uio_out;
  logic [7:0]            uio_oe;
  logic [NUM_PROJ-1:0]   proj_rst_n;
  logic [NUM_PROJ-1:0]   proj_ena;
  logic [SEL_W-1:0]      active_sel;
  logic                  switching;

  logic [2:0]  d5_sel_req;
  logic        d5_sel_valid;
  logic        d5_sel_ready;
  logic        d5_sel_err;
  logic [39:0] d5_proj_bus;
  logic [7:0]  d5_uo_out;
  logic [7:0]  d5_uio_out;
  logic [7:0]  d5_uio_oe;
  logic [4:0]  d5_proj_rst_n;
  logic [4:0]  d5_proj_ena;
  logic [2:0]  d5_active_sel;
  logic        d5_switching;

`ifdef TINY_PROJECT_MUX_SWITCH_CNT_EN
  logic [7:0] switch_cnt;
  logic [7:0] d5_switch_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: m_wait is the number of enabled edges still needed
  // before the selected project owns the pads (0 = owns them now);
  // RST_CYCLES+1 means the one-cycle isolation is still ahead.
  int         m_sel;
  int         m_target;
  int         m_wait;
  int         m_cnt;
  logic       m_err;
  logic [3:0] m_rstn;

  tiny_project_mux #(.NUM_PROJ(NUM_PROJ), .RST_CYCLES(RST_CYCLES), .DEFAULT_SEL(0)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .sel_req(sel_req), .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_err(sel_err),
    .proj_uo_out(proj_uo_out), .proj_uio_out(proj_uio_out), .proj_uio_oe(proj_uio_oe),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe),
    .proj_rst_n(proj_rst_n), .proj_ena(proj_ena), .active_sel(active_sel),
    .switching(switching)
`ifdef TINY_PROJECT_MUX_SWITCH_CNT_EN
    , .switch_cnt(switch_cnt)
`endif
  );

  tiny_project_mux #(.NUM_PROJ(5), .RST_CYCLES(3), .DEFAULT_SEL(0)) dut5 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .sel_req(d5_sel_req), .sel_valid(d5_sel_valid), .sel_ready(d5_sel_ready),
    .sel_err(d5_sel_err),
    .proj_uo_out(d5_proj_bus), .proj_uio_out(d5_proj_bus), .proj_uio_oe(d5_proj_bus),
    .uo_out(d5_uo_out), .uio_out(d5_uio_out), .uio_oe(d5_uio_oe),
    .proj_rst_n(d5_proj_rst_n), .proj_ena(d5_proj_ena), .active_sel(d5_active_sel),
    .switching(d5_switching)
`ifdef TINY_PROJECT_MUX_SWITCH_CNT_EN
    , .switch_cnt(d5_switch_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_sel    = 0;
    m_target = 0;
    m_wait   = RST_CYCLES;
    m_cnt    = 0;
    m_err    = 1'b0;
    m_rstn   = 4'b0000;
  endtask

  // Advances one clock edge, moving the model with the inputs the DUT sees
  // at that edge, and returns 1 time unit after the edge.
  task automatic tick();
    proj_uo_out  = $urandom;
    proj_uio_out = $urandom;
    proj_uio_oe  = $urandom;
    if (m_wait == RST_CYCLES + 1 && m_cnt < 255) m_cnt++;
    m_err = 1'b0;
    if (!ena) begin
      m_sel  = m_target;
      m_wait = RST_CYCLES;
    end else if (m_wait > 0) begin
      if (m_wait == RST_CYCLES + 1) m_sel = m_target;
      m_wait--;
    end else if (sel_valid) begin
      if (int'(sel_req) >= NUM_PROJ) begin
        m_err = 1'b1;
      end else if (int'(sel_req) != m_sel) begin
        m_target = int'(sel_req);
        m_wait   = RST_CYCLES + 1;
      end
    end
    m_rstn = (m_wait == 0 && ena) ? 4'(1 << m_sel) : 4'b0000;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (active_sel !== 2'd0 || proj_rst_n !== 4'b0000 || switching !== 1'b1 ||
        sel_ready !== 1'b0 || sel_err !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL reset_state: sel=%0d rst_n=%b sw=%b rdy=%b err=%b, required sel=0 rst_n=0000 sw=1 rdy=0 err=0",
               active_sel, proj_rst_n, switching, sel_ready, sel_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 1; k <= RST_CYCLES; k++) begin
      tick();
      n_checks++;
      if (k < RST_CYCLES) begin
        if (proj_rst_n !== 4'b0000 || uo_out !== 8'h00 || uio_oe !== 8'h00 || switching !== 1'b1) begin
          n_fails++;
          $display("[TB] FAIL reset_hold k=%0d: rst_n=%b uo=%h oe=%h sw=%b, required 0000/00/00/1",
                   k, proj_rst_n, uo_out, uio_oe, switching);
        end
      end else begin
        if (proj_rst_n !== 4'b0001 || uo_out !== proj_uo_out[7:0] || uio_oe !== proj_uio_oe[7:0] ||
            switching !== 1'b0) begin
          n_fails++;
          $display("[TB] FAIL reset_release: rst_n=%b uo=%h oe=%h sw=%b, required 0001/%h/%h/0",
                   proj_rst_n, uo_out, uio_oe, switching, proj_uo_out[7:0], proj_uio_oe[7:0]);
        end
      end
    end
  endtask

  task automatic test_switch();
    sel_req   = 2'd2;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    n_checks++;
    if (switching !== 1'b1 || uo_out !== 8'h00 || active_sel !== 2'd0 || sel_ready !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL switch_isolate: sw=%b uo=%h sel=%0d rdy=%b, required 1/00/0/0",
               switching, uo_out, active_sel, sel_ready);
    end
    tick();
    n_checks++;
    if (active_sel !== 2'd2 || proj_ena !== 4'b0100 || proj_rst_n !== 4'b0000) begin
      n_fails++;
      $display("[TB] FAIL switch_load: sel=%0d ena=%b rst_n=%b, required 2/0100/0000",
               active_sel, proj_ena, proj_rst_n);
    end
    for (int k = 1; k <= RST_CYCLES; k++) begin
      tick();
      n_checks++;
      if (k < RST_CYCLES) begin
        if (proj_rst_n !== 4'b0000 || uo_out !== 8'h00) begin
          n_fails++;
          $display("[TB] FAIL switch_hold k=%0d: rst_n=%b uo=%h, required 0000/00", k, proj_rst_n, uo_out);
        end
      end else if (proj_rst_n !== 4'b0100 || uo_out !== proj_uo_out[23:16] ||
                   uio_out !== proj_uio_out[23:16] || switching !== 1'b0) begin
        n_fails++;
        $display("[TB] FAIL switch_done: rst_n=%b uo=%h uio=%h sw=%b, required 0100/%h/%h/0",
                 proj_rst_n, uo_out, uio_out, switching, proj_uo_out[23:16], proj_uio_out[23:16]);
      end
    end
    // Re-requesting the active project is dropped without a switch.
    sel_req   = 2'd2;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    n_checks++;
    if (switching !== 1'b0 || active_sel !== 2'd2 || proj_rst_n !== 4'b0100) begin
      n_fails++;
      $display("[TB] FAIL same_sel_drop: sw=%b sel=%0d rst_n=%b, required 0/2/0100",
               switching, active_sel, proj_rst_n);
    end
  endtask

  task automatic test_ena_drop();
    sel_req   = 2'd1;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) tick();
    ena = 1'b0;
    #1;
    n_checks++;
    if (uo_out !== 8'h00 || uio_oe !== 8'h00 || proj_ena !== 4'b0000 || sel_ready !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL ena_low_comb: uo=%h oe=%h ena=%b rdy=%b, required 00/00/0000/0",
               uo_out, uio_oe, proj_ena, sel_ready);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (proj_rst_n !== 4'b0000 || switching !== 1'b1 || active_sel !== 2'd1) begin
        n_fails++;
        $display("[TB] FAIL ena_low_hold: rst_n=%b sw=%b sel=%0d, required 0000/1/1",
                 proj_rst_n, switching, active_sel);
      end
    end
    ena = 1'b1;
    for (int k = 1; k <= RST_CYCLES; k++) begin
      tick();
      n_checks++;
      if (k < RST_CYCLES) begin
        if (proj_rst_n !== 4'b0000 || switching !== 1'b1) begin
          n_fails++;
          $display("[TB] FAIL ena_restart k=%0d: rst_n=%b sw=%b, required 0000/1", k, proj_rst_n, switching);
        end
      end else if (proj_rst_n !== 4'b0010 || active_sel !== 2'd1 || uo_out !== proj_uo_out[15:8]) begin
        n_fails++;
        $display("[TB] FAIL ena_complete: rst_n=%b sel=%0d uo=%h, required 0010/1/%h",
                 proj_rst_n, active_sel, uo_out, proj_uo_out[15:8]);
      end
    end
  endtask

  task automatic test_reset_mid();
    sel_req   = 2'd3;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (active_sel !== 2'd0 || proj_rst_n !== 4'b0000 || switching !== 1'b1 || sel_err !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL reset_mid: sel=%0d rst_n=%b sw=%b err=%b, required 0/0000/1/0",
               active_sel, proj_rst_n, switching, sel_err);
    end
`ifdef TINY_PROJECT_MUX_SWITCH_CNT_EN
    n_checks++;
    if (switch_cnt !== 8'd0) begin
      n_fails++;
      $display("[TB] FAIL reset_mid_cnt: switch_cnt=%0d, required 0", switch_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < RST_CYCLES; k++) tick();
    n_checks++;
    if (active_sel !== 2'd0 || proj_rst_n !== 4'b0001) begin
      n_fails++;
      $display("[TB] FAIL reset_mid_discard: sel=%0d rst_n=%b, required 0/0001", active_sel, proj_rst_n);
    end
  endtask

  task automatic test_random();
    logic [36:0] act;
    logic [36:0] exp;
    logic        own;
    for (int c = 0; c < 400; c++) begin
      ena       = ($urandom_range(0, 15) != 0);
      sel_valid = $urandom_range(0, 1) == 1;
      sel_req   = 2'($urandom_range(0, 3));
      tick();
      own = (m_wait == 0) && ena;
      exp = {own ? proj_uo_out[8*m_sel +: 8] : 8'h00,
             own ? proj_uio_out[8*m_sel +: 8] : 8'h00,
             own ? proj_uio_oe[8*m_sel +: 8] : 8'h00,
             m_rstn,
             ena ? 4'(1 << m_sel) : 4'b0000,
             2'(m_sel), (m_wait != 0), own, m_err};
      act = {uo_out, uio_out, uio_oe, proj_rst_n, proj_ena, active_sel, switching, sel_ready, sel_err};
      n_checks++;
      if (act !== exp) begin
        n_fails++;
        $display("[TB] FAIL random c=%0d: got %h, required %h", c, act, exp);
      end
`ifdef TINY_PROJECT_MUX_SWITCH_CNT_EN
      n_checks++;
      if (switch_cnt !== 8'(m_cnt)) begin
        n_fails++;
        $display("[TB] FAIL random_cnt c=%0d: got %0d, required %0d", c, switch_cnt, m_cnt);
      end
`endif
    end
    sel_valid = 1'b0;
  endtask

  task automatic test_bad_req();
    ena = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    for (int r = 5; r <= 7; r += 2) begin
      d5_sel_req   = 3'(r);
      d5_sel_valid = 1'b1;
      tick();
      d5_sel_valid = 1'b0;
      n_checks++;
      if (d5_sel_err !== 1'b1 || d5_active_sel !== 3'd0 || d5_switching !== 1'b0) begin
        n_fails++;
        $display("[TB] FAIL bad_req_pulse r=%0d: err=%b sel=%0d sw=%b, required 1/0/0",
                 r, d5_sel_err, d5_active_sel, d5_switching);
      end
      tick();
      n_checks++;
      if (d5_sel_err !== 1'b0 || d5_switching !== 1'b0) begin
        n_fails++;
        $display("[TB] FAIL bad_req_single r=%0d: err=%b sw=%b, required 0/0", r, d5_sel_err, d5_switching);
      end
    end
    d5_sel_req   = 3'd4;
    d5_sel_valid = 1'b1;
    tick();
    d5_sel_valid = 1'b0;
    n_checks++;
    if (d5_sel_err !== 1'b0 || d5_switching !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL top_index_ok: err=%b sw=%b, required 0/1", d5_sel_err, d5_switching);
    end
    tick();
    n_checks++;
    if (d5_active_sel !== 3'd4) begin
      n_fails++;
      $display("[TB] FAIL top_index_load: sel=%0d, required 4", d5_active_sel);
    end
  endtask

`ifdef TINY_PROJECT_MUX_SWITCH_CNT_EN
  task automatic test_back_to_back();
    ena       = 1'b1;
    sel_valid = 1'b1;
    for (int c = 0; c < 3100; c++) begin
      sel_req = (m_sel == 0) ? 2'd1 : 2'd0;
      tick();
      n_checks++;
      if (switch_cnt !== 8'(m_cnt)) begin
        n_fails++;
        $display("[TB] FAIL b2b_cnt c=%0d: got %0d, required %0d", c, switch_cnt, m_cnt);
      end
    end
    sel_valid = 1'b0;
    n_checks++;
    if (switch_cnt !== 8'd255) begin
      n_fails++;
      $display("[TB] FAIL b2b_saturate: got %0d, required 255", switch_cnt);
    end
  endtask
`endif

  initial begin
    rst_n        = 1'b0;
    ena          = 1'b1;
    sel_valid    = 1'b0;
    sel_req      = 2'd0;
    d5_sel_valid = 1'b0;
    d5_sel_req   = 3'd0;
    d5_proj_bus  = 40'h0;
    proj_uo_out  = 32'h44332211;
    proj_uio_out = 32'h88776655;
    proj_uio_oe  = 32'hccbbaa99;
    model_reset();
    test_reset();
    test_switch();
    test_ena_drop();
    test_reset_mid();
    test_random();
    test_bad_req();
`ifdef TINY_PROJECT_MUX_SWITCH_CNT_EN
    test_back_to_back();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
